conv1d_mac_pipe: RTL and testbench

Parametrised, pipelined signed multiply-accumulate engine for the Conv1d datapath. It supersedes the single-cycle 16x16 DSP48 multiplier wrapper. It accepts one sample/weight pair per cycle, accumulates TAPS products onto a bias, then rounds, shifts and saturates the sum to the output width. It sits between the sample line buffer / weight ROM and the activation stage, with valid/ready handshakes on both sides.

---
 rtl/conv1d_mac_pkg.sv | 51 +++++
 rtl/conv1d_mac_round_sat.sv | 26 ++
 rtl/conv1d_mac_pipe.sv | 123 ++++++++++++
 tb/tb_conv1d_mac_pipe.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/conv1d_mac_pkg.sv
// Shared widths and helpers for the pipelined Conv1d multiply-accumulate engine.
package conv1d_mac_pkg;

  localparam int DEF_DIN0_WIDTH = 16;
  localparam int DEF_DIN1_WIDTH = 16;
  localparam int DEF_ACC_WIDTH  = 40;
  localparam int DEF_DOUT_WIDTH = 16;

  // Working width for the round/saturate helper; accumulators must fit below it.
  localparam int RS_W = 64;

  typedef struct packed {
    logic signed [RS_W-1:0] value;
    logic                   sat;
  } rs_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  function automatic int idx_width(input int taps);
    return (clog2(taps) < 1) ? 1 : clog2(taps);
  endfunction

  function automatic bit acc_width_ok(input int d0w, input int d1w, input int accw, input int taps);
    return (taps >= 1) && (accw >= d0w + d1w + clog2(taps) + 1) && (accw < RS_W);
  endfunction

  // Round half up, arithmetic shift, then clamp into a dout_width signed range.
  function automatic rs_t round_sat(input logic signed [RS_W-1:0] acc, input int frac_shift,
                                    input int dout_width);
    rs_t                    res;
    logic signed [RS_W-1:0] r;
    logic signed [RS_W-1:0] maxv;
    logic signed [RS_W-1:0] minv;
    r = acc;
    if (frac_shift > 0) r = r + (64'sd1 <<< (frac_shift - 1));
    r = r >>> frac_shift;
    maxv = (64'sd1 <<< (dout_width - 1)) - 64'sd1;
    minv = -maxv - 64'sd1;
    res.sat = (r > maxv) || (r < minv);
    if (r > maxv)      res.value = maxv;
    else if (r < minv) res.value = minv;
    else               res.value = r;
    return res;
  endfunction

endpackage

// File: rtl/conv1d_mac_round_sat.sv
// Combinational output stage: rounds and shifts the accumulator, then saturates to DOUT_WIDTH.
module conv1d_mac_round_sat
  import conv1d_mac_pkg::*;
#(
  parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
  parameter int FRAC_SHIFT = 8,
  parameter int DOUT_WIDTH = DEF_DOUT_WIDTH
) (
  input  logic signed [ACC_WIDTH-1:0]  acc,
  output logic signed [DOUT_WIDTH-1:0] dout,
  output logic                         sat
);

  rs_t  rs;
  logic unused_hi;

  always_comb begin
    rs = round_sat({{(RS_W - ACC_WIDTH){acc[ACC_WIDTH-1]}}, acc}, FRAC_SHIFT, DOUT_WIDTH);
  end

  // After clamping the upper bits are pure sign extension.
  assign dout      = rs.value[DOUT_WIDTH-1:0];
  assign sat       = rs.sat;
  assign unused_hi = ^rs.value[RS_W-1:DOUT_WIDTH];

endmodule

// File: rtl/conv1d_mac_pipe.sv
// Four-stage signed MAC: input register, product, accumulate onto bias, round/saturate output.
module conv1d_mac_pipe
  import conv1d_mac_pkg::*;
#(
  parameter int DIN0_WIDTH = DEF_DIN0_WIDTH,
  parameter int DIN1_WIDTH = DEF_DIN1_WIDTH,
  parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
  parameter int TAPS       = 5,
  parameter int FRAC_SHIFT = 8,
  parameter int DOUT_WIDTH = DEF_DOUT_WIDTH,
  localparam int TW        = idx_width(TAPS)
) (
  input  logic                         ap_clk,
  input  logic                         ap_rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [DIN0_WIDTH-1:0] din0,
  input  logic signed [DIN1_WIDTH-1:0] din1,
  input  logic signed [ACC_WIDTH-1:0]  bias,
  output logic [TW-1:0]                tap_idx,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [DOUT_WIDTH-1:0] dout,
  output logic                         out_sat
);

  localparam int PW = DIN0_WIDTH + DIN1_WIDTH;
  localparam logic [TW-1:0] LAST_TAP = TW'(TAPS - 1);

  if (!acc_width_ok(DIN0_WIDTH, DIN1_WIDTH, ACC_WIDTH, TAPS)) begin : g_bad_acc_width
    $error("conv1d_mac_pipe: ACC_WIDTH too small for DIN widths and TAPS");
  end

  logic [TW-1:0]                tap_reg;
  logic                         s1_valid_reg, s1_first_reg, s1_last_reg;
  logic signed [DIN0_WIDTH-1:0] s1_din0_reg;
  logic signed [DIN1_WIDTH-1:0] s1_din1_reg;
  logic signed [ACC_WIDTH-1:0]  s1_bias_reg;
  logic                         s2_valid_reg, s2_first_reg, s2_last_reg;
  logic signed [ACC_WIDTH-1:0]  s2_prod_reg, s2_bias_reg;
  logic                         s3_valid_reg;
  logic signed [ACC_WIDTH-1:0]  acc_reg;
  logic                         out_valid_reg, out_sat_reg;
  logic signed [DOUT_WIDTH-1:0] dout_reg;

  logic                         en;
  logic signed [PW-1:0]         prod;
  logic signed [DOUT_WIDTH-1:0] rs_dout;
  logic                         rs_sat;

  // The whole pipeline freezes only while a finished result waits on downstream.
  assign en       = !(out_valid_reg && !out_ready);
  assign in_ready = en;
  assign prod     = s1_din0_reg * s1_din1_reg;

  conv1d_mac_round_sat #(
    .ACC_WIDTH (ACC_WIDTH),
    .FRAC_SHIFT(FRAC_SHIFT),
    .DOUT_WIDTH(DOUT_WIDTH)
  ) u_round_sat (
    .acc (acc_reg),
    .dout(rs_dout),
    .sat (rs_sat)
  );

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      tap_reg       <= '0;
      s1_valid_reg  <= 1'b0;
      s1_first_reg  <= 1'b0;
      s1_last_reg   <= 1'b0;
      s1_din0_reg   <= '0;
      s1_din1_reg   <= '0;
      s1_bias_reg   <= '0;
      s2_valid_reg  <= 1'b0;
      s2_first_reg  <= 1'b0;
      s2_last_reg   <= 1'b0;
      s2_prod_reg   <= '0;
      s2_bias_reg   <= '0;
      s3_valid_reg  <= 1'b0;
      acc_reg       <= '0;
      out_valid_reg <= 1'b0;
      out_sat_reg   <= 1'b0;
      dout_reg      <= '0;
    end else if (en) begin
      s1_valid_reg <= in_valid;
      if (in_valid) begin
        tap_reg      <= (tap_reg == LAST_TAP) ? '0 : tap_reg + 1'b1;
        s1_din0_reg  <= din0;
        s1_din1_reg  <= din1;
        s1_bias_reg  <= bias;
        s1_first_reg <= (tap_reg == '0);
        s1_last_reg  <= (tap_reg == LAST_TAP);
      end

      s2_valid_reg <= s1_valid_reg;
      if (s1_valid_reg) begin
        s2_prod_reg  <= {{(ACC_WIDTH - PW){prod[PW-1]}}, prod};
        s2_bias_reg  <= s1_bias_reg;
        s2_first_reg <= s1_first_reg;
        s2_last_reg  <= s1_last_reg;
      end

      // s3_valid marks that acc_reg now holds a completed window.
      s3_valid_reg <= s2_valid_reg && s2_last_reg;
      if (s2_valid_reg) acc_reg <= (s2_first_reg ? s2_bias_reg : acc_reg) + s2_prod_reg;

      if (s3_valid_reg) begin
        out_valid_reg <= 1'b1;
        dout_reg      <= rs_dout;
        out_sat_reg   <= rs_sat;
      end else if (out_ready) begin
        out_valid_reg <= 1'b0;
      end
    end
  end

  assign tap_idx   = tap_reg;
  assign out_valid = out_valid_reg;
  assign dout      = dout_reg;
  assign out_sat   = out_sat_reg;

endmodule

// File: tb/tb_conv1d_mac_pipe.sv
// Directed bench for conv1d_mac_pipe (TAPS=3, FRAC_SHIFT=8) with a window-level reference model.
module tb_conv1d_mac_pipe;

  localparam int TAPS = 3;
  localparam int FRAC = 8;
  localparam int DW   = 16;

  logic               ap_clk = 1'b0;
  logic               ap_rst_n;
  logic               in_valid;
  logic               in_ready;
  logic signed [15:0] din0;
  logic signed [15:0] din1;
  logic signed [39:0] bias;
  logic [1:0]         tap_idx;
  logic               out_valid;
  logic               out_ready;
  logic signed [15:0] dout;
  logic               out_sat;

  conv1d_mac_pipe #(
    .DIN0_WIDTH(16), .DIN1_WIDTH(16), .ACC_WIDTH(40),
    .TAPS(TAPS), .FRAC_SHIFT(FRAC), .DOUT_WIDTH(DW)
  ) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .din0(din0), .din1(din1), .bias(bias), .tap_idx(tap_idx),
    .out_valid(out_valid), .out_ready(out_ready), .dout(dout), .out_sat(out_sat)
  );

  always #5 ap_clk = ~ap_clk;

  typedef struct {
    longint v;
    bit     s;
  } res_t;

  int     total = 0;
  int     bad = 0;
  res_t   exp_q[$];
  res_t   lit_q[$];
  int     m_tap = 0;
  longint m_sum = 0;
  int     cyc = 0;
  bit     stall_prev = 0;
  longint hold_dout = 0;
  longint hold_tap = 0;
  bit     lat_arm = 0;
  bit     lat_pending = 0;
  int     lat_cyc = 0;

  task automatic check(input string nm, input longint act, input longint req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Window result from plain arithmetic: floor(sum/2^F + 1/2), then clamp.
  function automatic res_t model_result(input longint sum);
    res_t   r;
    longint maxv, minv, q;
    maxv = (longint'(1) << (DW - 1)) - 1;
    minv = -(longint'(1) << (DW - 1));
    q = longint'($floor(real'(sum) / (2.0 ** FRAC) + 0.5));
    r.s = (q > maxv) || (q < minv);
    r.v = (q > maxv) ? maxv : ((q < minv) ? minv : q);
    return r;
  endfunction

  always @(negedge ap_clk) begin
    cyc++;
    if (!ap_rst_n) begin
      m_tap = 0;
      exp_q.delete();
      stall_prev = 0;
      lat_pending = 0;
    end else begin
      check("tap_idx", tap_idx, m_tap);
      check("in_ready", in_ready, !(out_valid && !out_ready));
      if (stall_prev) begin
        check("dout_hold", dout, hold_dout);
        check("tap_hold", tap_idx, hold_tap);
      end
      if (lat_pending) begin
        if (out_valid) begin
          check("latency", cyc - lat_cyc, 4);
          lat_pending = 0;
        end else if (cyc - lat_cyc > 20) begin
          check("latency_timeout", out_valid, 1);
          lat_pending = 0;
        end
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", dout, -99999);
        end else begin
          res_t e;
          e = exp_q.pop_front();
          check("dout_model", dout, e.v);
          check("sat_model", out_sat, e.s);
        end
        if (lit_q.size() == 0) begin
          check("lit_missing", dout, -99999);
        end else begin
          res_t l;
          l = lit_q.pop_front();
          check("dout_literal", dout, l.v);
          check("sat_literal", out_sat, l.s);
        end
      end
      stall_prev = out_valid && !out_ready;
      hold_dout  = dout;
      hold_tap   = tap_idx;
      if (in_valid && in_ready) begin
        if (m_tap == 0) m_sum = bias;
        m_sum += longint'(din0) * longint'(din1);
        if (m_tap == TAPS - 1) begin
          exp_q.push_back(model_result(m_sum));
          if (lat_arm) begin
            lat_arm = 0;
            lat_pending = 1;
            lat_cyc = cyc;
          end
        end
        m_tap = (m_tap + 1) % TAPS;
      end
    end
  end

  task automatic send_pair(input int a, input int w, input longint b);
    int n;
    in_valid = 1'b1;
    din0 = 16'(a);
    din1 = 16'(w);
    bias = 40'(b);
    n = 0;
    @(negedge ap_clk);
    while (!in_ready && n < 100) begin
      n++;
      @(negedge ap_clk);
    end
    if (!in_ready) check("accept_timeout", in_ready, 1);
    @(posedge ap_clk);
    #1;
  endtask

  task automatic send_win(input longint b, input int a0, input int w0, input int a1,
                          input int w1, input int a2, input int w2, input longint ed,
                          input bit es);
    res_t l;
    l.v = ed;
    l.s = es;
    lit_q.push_back(l);
    send_pair(a0, w0, b);
    send_pair(a1, w1, b);
    send_pair(a2, w2, b);
  endtask

  task automatic wait_idle();
    int n;
    in_valid = 1'b0;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 100) begin
      n++;
      @(negedge ap_clk);
    end
    check("drain_timeout", exp_q.size(), 0);
    @(posedge ap_clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ap_rst_n = 1'b0;
    in_valid = 1'b1;
    din0 = 16'sd100;
    din1 = 16'sd100;
    bias = 40'sd5;
    out_ready = 1'b1;
    repeat (2) @(posedge ap_clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_dout", dout, 0);
    check("rst_out_sat", out_sat, 0);
    check("rst_tap_idx", tap_idx, 0);
    ap_rst_n = 1'b1;
    in_valid = 1'b0;
    @(posedge ap_clk);
    #1;
    check("rst_in_ready", in_ready, 1);

    // Basic windows, back to back; first one also checks latency.
    lat_arm = 1;
    send_win(0, 256, 256, 512, 256, -256, 256, 512, 0);
    send_win(65536, 256, 256, 512, 256, -256, 256, 768, 0);
    wait_idle();

    // Rounding
    send_win(0, 1, 128, 1, 128, 1, 128, 2, 0);
    send_win(0, -1, 128, -1, 128, -1, 128, -1, 0);
    send_win(0, 1, 127, 1, 127, 1, 127, 1, 0);
    wait_idle();

    // Saturation
    send_win(0, 32767, 32767, 32767, 32767, 32767, 32767, 32767, 1);
    send_win(0, -32768, 32767, -32768, 32767, -32768, 32767, -32768, 1);
    wait_idle();

    // Backpressure with a second window arriving mid-stall
    out_ready = 1'b0;
    fork
      begin
        send_win(0, 256, 256, 256, 256, 256, 256, 768, 0);
        in_valid = 1'b0;
        @(posedge ap_clk);
        #1;
        send_win(0, 512, 256, 512, 256, 512, 256, 1536, 0);
      end
      begin
        int n;
        n = 0;
        @(negedge ap_clk);
        while (!out_valid && n < 100) begin
          n++;
          @(negedge ap_clk);
        end
        check("bp_result_seen", out_valid, 1);
        check("bp_in_ready_low", in_ready, 0);
        repeat (4) @(posedge ap_clk);
        #1;
        out_ready = 1'b1;
      end
    join
    wait_idle();

    // Reset in the middle of a window discards the partial sum
    send_pair(1000, 1000, 99999);
    send_pair(-700, 300, 99999);
    ap_rst_n = 1'b0;
    in_valid = 1'b0;
    @(posedge ap_clk);
    #1;
    ap_rst_n = 1'b1;
    send_win(0, 256, 256, 512, 256, -256, 256, 512, 0);
    wait_idle();

    check("leftover_results", exp_q.size() + lit_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
